// File: rtl/shift_arbiter.sv
// Round-robin front end for one shared 32-bit barrel shifter: one request in flight,
// response returned with its requester id. Accept in T, response valid in T+2.
module shift_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [5*N_REQ-1:0]   req_amt,
  input  logic [2*N_REQ-1:0]   req_op,
  output logic [31:0]          sh_in,
  output logic [4:0]           sh_amt,
  output logic [1:0]           sh_op,
  input  logic [31:0]          sh_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_rsp_id;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_valid;
  logic [31:0]      r_sh_in;
  logic [4:0]       r_sh_amt;
  logic [1:0]       r_sh_op;
  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt;
  logic             w_accept;
  logic [N_REQ-1:0] w_req_ready;

  // Requester k places after the last winner, wrapping at N_REQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N_REQ);
  endfunction

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_gnt_vld && req_valid[rr_idx(r_last, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = rr_idx(r_last, k);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_gnt_vld;

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shifter operands change only on an accept edge and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_in     <= '0;
      r_sh_amt    <= '0;
      r_sh_op     <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_last      <= IDW'(N_REQ - 1);
    end else begin
      if (w_accept) begin
        r_sh_in  <= req_data[32*w_gnt +: 32];
        r_sh_amt <= req_amt[5*w_gnt +: 5];
        r_sh_op  <= req_op[2*w_gnt +: 2];
        r_rsp_id <= w_gnt;
        r_last   <= w_gnt;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data  <= sh_out;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign sh_in     = r_sh_in;
  assign sh_amt    = r_sh_amt;
  assign sh_op     = r_sh_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);

endmodule
